md_sequencer: RTL and testbench

- Sequences the shared multi-cycle mult/div unit on behalf of the pipeline.
- Accepts one request at a time and latches its operands, holding them stable on unit_A/unit_B for the whole operation, because the divider re-reads A[31]/B[31] at completion.
- Issues a single-cycle ctrl_MULT/ctrl_DIV start pulse, waits for RDY, and returns result, exception and destination tag on a valid/ready writeback port.
- Stalls the pipeline while the unit is occupied.

---
 rtl/md_sequencer.sv | 128 ++++++++++++
 tb/tb_md_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
// md_sequencer: issues one request at a time to the shared multi-cycle
// mult/div unit. It holds the operands, sends a start pulse, waits for RDY
// or a timeout, and returns the result on a valid/ready writeback port.
// Optional: MD_DIV0_FAST_EN completes divide-by-zero locally. The unit is
// never started for that case.
module md_sequencer #(
  parameter int DATA_W  = 32,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_op,
  input  logic [DATA_W-1:0] req_A,
  input  logic [DATA_W-1:0] req_B,
  input  logic [RD_W-1:0]   req_rd,
  output logic              req_ready,
  output logic              stall,
  output logic              busy,
  input  logic              flush,
  output logic              ctrl_MULT,
  output logic              ctrl_DIV,
  output logic [DATA_W-1:0] unit_A,
  output logic [DATA_W-1:0] unit_B,
  input  logic [DATA_W-1:0] unit_result,
  input  logic              unit_exception,
  input  logic              unit_RDY,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_exception
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  state_t            state;
  logic              op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [RD_W-1:0]   rd_q;
  logic [CNT_W-1:0]  cnt;
  logic              accept;

  // Handshake decode. Flush and reset block acceptance in the same cycle.
  assign req_ready = (state == IDLE) & ~flush & ~reset;
  assign accept    = req_valid & req_ready;
  assign stall     = req_valid & ~req_ready;
  assign busy      = (state != IDLE);
  assign unit_A    = a_q;
  assign unit_B    = b_q;

  // The start pulse is decoded from START so that a flush in that same
  // cycle can still suppress it.
  assign ctrl_MULT = (state == START) & ~op_q & ~flush & ~reset;
  assign ctrl_DIV  = (state == START) &  op_q & ~flush & ~reset;

  // Sequencer FSM: latch operands, start the unit, wait for RDY or timeout,
  // then hold the writeback until the consumer takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      op_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      rd_q         <= '0;
      cnt          <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_exception <= 1'b0;
    end else if (flush) begin
      state    <= IDLE;
      wb_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q <= req_op;
          a_q  <= req_A;
          b_q  <= req_B;
          rd_q <= req_rd;
`ifdef MD_DIV0_FAST_EN
          if (req_op && req_B == '0) begin
            state        <= DONE;
            wb_valid     <= 1'b1;
            wb_data      <= '0;
            wb_rd        <= req_rd;
            wb_exception <= 1'b1;
          end else begin
            state <= START;
          end
`else
          state <= START;
`endif
        end
        START: begin
          cnt   <= '0;
          state <= BUSY;
        end
        BUSY: begin
          if (unit_RDY) begin
            state        <= DONE;
            wb_valid     <= 1'b1;
            wb_data      <= unit_result;
            wb_rd        <= rd_q;
            wb_exception <= unit_exception;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            // The unit never answered. Complete with an error so that the
            // pipeline cannot hang.
            state        <= DONE;
            wb_valid     <= 1'b1;
            wb_data      <= '0;
            wb_rd        <= rd_q;
            wb_exception <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: if (wb_ready) begin
          state    <= IDLE;
          wb_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: table-driven bench with a scoreboard queue. A procedural
// stub stands in for the mult/div unit.
module tb_md_sequencer;
  localparam int DATA_W  = 32;
  localparam int RD_W    = 5;
  localparam int TIMEOUT = 40;

  logic              clk = 1'b0;
  logic              reset, req_valid, req_op, flush;
  logic [DATA_W-1:0] req_A, req_B, unit_result;
  logic [RD_W-1:0]   req_rd;
  logic              unit_exception, unit_RDY, wb_ready;
  logic              req_ready, stall, busy, ctrl_MULT, ctrl_DIV;
  logic [DATA_W-1:0] unit_A, unit_B, wb_data;
  logic [RD_W-1:0]   wb_rd;
  logic              wb_valid, wb_exception;

  md_sequencer #(.DATA_W(DATA_W), .RD_W(RD_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_A(req_A), .req_B(req_B), .req_rd(req_rd), .req_ready(req_ready),
    .stall(stall), .busy(busy), .flush(flush), .ctrl_MULT(ctrl_MULT),
    .ctrl_DIV(ctrl_DIV), .unit_A(unit_A), .unit_B(unit_B),
    .unit_result(unit_result), .unit_exception(unit_exception),
    .unit_RDY(unit_RDY), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_exception(wb_exception)
  );

  always #5 clk = ~clk;

  // k = cycles after START until the stub raises RDY (0 = never)
  typedef struct {
    logic              op;
    logic [DATA_W-1:0] a, b;
    logic [RD_W-1:0]   rd;
    int                k;
    logic [DATA_W-1:0] res;
    logic              exc;
    int                hold;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
    logic              exc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   ntests = 0;
  int   nfail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour derived from the block's contract.
  task automatic model(input vec_t v, output exp_t e, output int lat,
                       output int nm, output int nd);
    bit fast = 1'b0;
`ifdef MD_DIV0_FAST_EN
    fast = v.op && (v.b == '0);
`endif
    nm = v.op ? 0 : 1;
    nd = v.op ? 1 : 0;
    if (fast) begin
      e = '{'0, v.rd, 1'b1}; lat = 1; nm = 0; nd = 0;
    end else if (v.k == 0 || v.k > TIMEOUT) begin
      e = '{'0, v.rd, 1'b1}; lat = TIMEOUT + 2;
    end else begin
      e = '{v.res, v.rd, v.exc}; lat = v.k + 2;
    end
  endtask

  // Called at a negedge while the DUT is idle. Returns at a negedge, idle.
  task automatic do_op(input string tag, input vec_t v);
    exp_t e, got;
    int lat, nm, nd, cyc, seen_m, seen_d;
    bit opnd_bad, pulse_bad, hold_bad;
    logic [DATA_W-1:0] d0;
    model(v, e, lat, nm, nd);
    req_valid = 1'b1; req_op = v.op; req_A = v.a; req_B = v.b; req_rd = v.rd;
    #1 chk({tag, " req_ready"}, req_ready, 1);
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; seen_m = 0; seen_d = 0; opnd_bad = 0; pulse_bad = 0;
    while (!wb_valid && cyc < 200) begin
      if (ctrl_MULT) seen_m++;
      if (ctrl_DIV)  seen_d++;
      if ((ctrl_MULT || ctrl_DIV) && cyc != 1) pulse_bad = 1;
      if (unit_A !== v.a || unit_B !== v.b) opnd_bad = 1;
      unit_RDY       = (v.k != 0) && (cyc == v.k + 1);
      unit_result    = v.res;
      unit_exception = v.exc;
      @(negedge clk);
      cyc++;
    end
    unit_RDY = 1'b0;
    chk({tag, " latency"}, cyc, lat);
    chk({tag, " mult_pulses"}, seen_m, nm);
    chk({tag, " div_pulses"}, seen_d, nd);
    chk({tag, " pulse_timing"}, pulse_bad, 0);
    chk({tag, " operands_stable"}, opnd_bad, 0);
    d0 = wb_data; hold_bad = 0;
    req_valid = 1'b1; req_op = 1'b0;
    for (int h = 0; h < v.hold; h++) begin
      wb_ready = 1'b0;
      #1 if (!(stall && !req_ready && wb_valid && wb_data === d0)) hold_bad = 1;
      @(negedge clk);
    end
    if (v.hold > 0) chk({tag, " hold_stall"}, hold_bad, 0);
    wb_ready = 1'b1;
    #1 chk({tag, " no_accept_at_wb"}, req_ready, 0);
    if (sb.size() == 0) chk({tag, " sb_empty"}, 1, 0);
    else begin
      got = sb.pop_front();
      chk({tag, " wb_data"}, wb_data, got.data);
      chk({tag, " wb_rd"}, wb_rd, got.rd);
      chk({tag, " wb_exc"}, wb_exception, got.exc);
    end
    @(negedge clk);
    wb_ready = 1'b0; req_valid = 1'b0;
    #1 chk({tag, " idle_after"}, {busy, wb_valid, req_ready}, 3'b001);
  endtask

  initial begin
    bit seen;
    vec_t v;
    reset = 1'b1; req_valid = 0; req_op = 0; req_A = 0; req_B = 0; req_rd = 0;
    flush = 0; unit_result = 0; unit_exception = 0; unit_RDY = 0; wb_ready = 0;

    vecs[0] = '{1'b1, 32'd100, 32'd7, 5'd5, 33, 32'd14, 1'b0, 0};
    vecs[1] = '{1'b0, 32'd6, 32'd7, 5'd9, 1, 32'd42, 1'b0, 5};
    vecs[2] = '{1'b0, 32'd3, 32'd4, 5'd1, 0, 32'hDEAD, 1'b0, 0};
    vecs[3] = '{1'b1, 32'h8000_0000, 32'd0, 5'd31, 5, 32'hFFFF_FFFF, 1'b1, 1};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'h2, 5'd17, 34, 32'h1234_5678, 1'b1, 2};
    vecs[5] = '{1'b1, 32'd9, 32'd3, 5'd2, 40, 32'd3, 1'b0, 0};
    vecs[6] = '{1'b1, 32'd9, 32'd3, 5'd4, 41, 32'd3, 1'b0, 0};

    repeat (2) @(negedge clk);
    #1 chk("reset req_ready", req_ready, 0);
    chk("reset outs", {busy, wb_valid, ctrl_MULT, ctrl_DIV, wb_exception}, 0);
    chk("reset data", {wb_data, unit_A}, 0);
    reset = 1'b0;
    #1 chk("post-reset req_ready", req_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 7; i++) do_op($sformatf("vec%0d", i), vecs[i]);

    // flush and request in IDLE: flush wins
    req_valid = 1; req_op = 1; req_A = 5; req_B = 1; req_rd = 3; flush = 1;
    #1 chk("flush_idle req_ready", req_ready, 0);
    @(negedge clk);
    req_valid = 0; flush = 0;
    #1 chk("flush_idle busy", busy, 0);

    // flush in the START cycle suppresses the pulse
    req_valid = 1; req_op = 0; req_A = 2; req_B = 2;
    @(negedge clk);
    req_valid = 0; flush = 1;
    #1 chk("flush_start pulse", {ctrl_MULT, ctrl_DIV}, 0);
    @(negedge clk);
    flush = 0;
    #1 chk("flush_start busy", busy, 0);

    // flush in BUSY cycle 10 with RDY in the same cycle: result dropped
    req_valid = 1; req_op = 1; req_A = 11; req_B = 13; req_rd = 3;
    @(negedge clk);
    req_valid = 0;
    repeat (10) @(negedge clk);
    #1 chk("flush_busy busy", busy, 1);
    flush = 1; unit_RDY = 1; unit_result = 32'd77;
    @(negedge clk);
    flush = 0; unit_RDY = 0;
    seen = 0;
    repeat (3) begin
      #1 if (wb_valid || busy) seen = 1;
      @(negedge clk);
    end
    chk("flush_busy no_wb", seen, 0);
    v = '{1'b1, 32'hFFFF_FFF8, 32'd2, 5'd12, 3, 32'hFFFF_FFFC, 1'b0, 0};
    do_op("after_flush", v);

    // reset in BUSY with RDY in the same cycle
    req_valid = 1; req_op = 1; req_A = 50; req_B = 5; req_rd = 7;
    @(negedge clk);
    req_valid = 0;
    repeat (3) @(negedge clk);
    reset = 1; unit_RDY = 1; unit_result = 32'd10;
    @(negedge clk);
    #1 chk("rst_busy outs", {busy, wb_valid, ctrl_MULT, ctrl_DIV, wb_exception, req_ready}, 0);
    chk("rst_busy regs", {wb_data, unit_A, unit_B, wb_rd}, 0);
    reset = 0; unit_RDY = 0;
    #1 chk("rst_busy req_ready", req_ready, 1);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      #1 if (wb_valid) seen = 1;
    end
    chk("rst_busy no_wb", seen, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
